// File: rtl/mem_access_stage.sv
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : MIPS MEM stage - handshaked data-memory access, upstream stall,
//             MEM/WB pipeline register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic        ex_regwrite,
    input  logic        ex_memtoreg,
    input  logic [4:0]  ex_write_reg,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic [31:0] wb_rd,
    output logic [31:0] wb_address,
    output logic        wb_memtoreg,
    output logic        wb_regwrite,
    output logic [4:0]  wb_write_reg,
    output logic        misalign_err,
    output logic        timeout_err
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    // Counter only ever needs to reach ACK_TIMEOUT-1 before forcing completion.
    localparam int          C_CW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam bit          C_TO_EN    = (ACK_TIMEOUT != 0);
    localparam int unsigned C_TO_LAST  = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;
    localparam logic [C_CW-1:0] C_TO_LAST_W = C_CW'(C_TO_LAST);

    state_t          r_state;
    logic [C_CW-1:0] r_count;

    logic w_memop;
    logic w_aligned;
    logic w_in_access;
    logic w_timeout_hit;
    logic w_is_load;

    assign w_memop       = ex_valid & (ex_memread | ex_memwrite);
    assign w_aligned     = (ex_alu_result[1:0] == 2'b00);
    assign w_in_access   = (r_state == S_ACCESS);
    assign w_is_load     = ex_memread;
    assign w_timeout_hit = C_TO_EN & w_in_access & (r_count == C_TO_LAST_W) & ~dmem_ack;

    // Released in the ack/timeout cycle so upstream advances on the completing edge.
    assign mem_stall = (~w_in_access & w_memop & w_aligned)
                     | (w_in_access & ~dmem_ack & ~w_timeout_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_address   <= '0;
            wb_memtoreg  <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_write_reg <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_memop && w_aligned) begin
                        r_state     <= S_ACCESS;
                        r_count     <= '0;
                        dmem_req    <= 1'b1;
                        dmem_we     <= ex_memwrite & ~ex_memread;
                        dmem_addr   <= ex_alu_result;
                        dmem_wdata  <= ex_store_data;
                        wb_valid    <= 1'b0;
                        wb_regwrite <= 1'b0;
                    end else begin
                        // Non-memory ops and dropped misaligned accesses retire in one cycle.
                        wb_valid     <= ex_valid;
                        wb_rd        <= '0;
                        wb_address   <= ex_alu_result;
                        wb_memtoreg  <= ex_memtoreg;
                        wb_write_reg <= ex_write_reg;
                        wb_regwrite  <= ex_valid & ex_regwrite & ~w_memop;
                        misalign_err <= w_memop;
                    end
                end
                S_ACCESS: begin
                    if (dmem_ack || w_timeout_hit) begin
                        r_state      <= S_IDLE;
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_address   <= ex_alu_result;
                        wb_memtoreg  <= ex_memtoreg;
                        wb_write_reg <= ex_write_reg;
                        if (dmem_ack) begin
                            wb_rd       <= w_is_load ? dmem_rdata : 32'h0;
                            wb_regwrite <= ex_valid & ex_regwrite;
                        end else begin
                            wb_rd       <= w_is_load ? ERR_DATA : 32'h0;
                            wb_regwrite <= 1'b0;
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Randomized self-checking bench for mem_access_stage against a
//             transaction-level schedule model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_write_reg;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_memtoreg, wb_regwrite, misalign_err, timeout_err;
    logic [31:0] wb_rd, wb_address;
    logic [4:0]  wb_write_reg;

    int n_total = 0;
    int n_bad   = 0;

    // Expected registered-output state for the current cycle
    logic        exp_wv, exp_rw, exp_m2r, exp_mis, exp_to, exp_req, exp_we;
    logic [31:0] exp_rd, exp_addr, exp_daddr, exp_wdata;
    logic [4:0]  exp_wreg;

    logic [31:0] mem [logic [31:0]];

    mem_access_stage #(.ACK_TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
        .ex_memtoreg(ex_memtoreg), .ex_write_reg(ex_write_reg),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_address(wb_address),
        .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_write_reg(wb_write_reg),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("wb_valid", 32'(wb_valid), 32'(exp_wv));
        check_eq("wb_regwrite", 32'(wb_regwrite), 32'(exp_rw));
        if (exp_wv) begin
            check_eq("wb_rd", wb_rd, exp_rd);
            check_eq("wb_address", wb_address, exp_addr);
            check_eq("wb_memtoreg", 32'(wb_memtoreg), 32'(exp_m2r));
            check_eq("wb_write_reg", 32'(wb_write_reg), 32'(exp_wreg));
        end
        check_eq("misalign_err", 32'(misalign_err), 32'(exp_mis));
        check_eq("timeout_err", 32'(timeout_err), 32'(exp_to));
        check_eq("dmem_req", 32'(dmem_req), 32'(exp_req));
        if (exp_req) begin
            check_eq("dmem_addr", dmem_addr, exp_daddr);
            check_eq("dmem_we", 32'(dmem_we), 32'(exp_we));
            check_eq("dmem_wdata", dmem_wdata, exp_wdata);
        end
    endtask

    // One instruction: d = ACCESS cycles before ack (0 = same cycle as req); d >= TO never acks.
    task automatic do_op(input bit v, input logic [31:0] a, input logic [31:0] wd,
                         input bit rd_en, input bit wr_en, input bit rw, input bit m2r,
                         input logic [4:0] wreg, input int d);
        bit memop, al, is_load, to;
        int k;
        logic [31:0] ld_val;
        memop   = v && (rd_en || wr_en);
        al      = (a[1:0] == 2'b00);
        is_load = rd_en;
        ex_valid = v; ex_alu_result = a; ex_store_data = wd;
        ex_memread = rd_en; ex_memwrite = wr_en; ex_regwrite = rw;
        ex_memtoreg = m2r; ex_write_reg = wreg;
        dmem_ack   = ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
        #1 check_eq("mem_stall_accept", 32'(mem_stall), 32'(memop && al));
        if (!(memop && al)) begin
            @(posedge clk); #1;
            exp_wv = v; exp_rw = v && rw && !memop; exp_rd = 32'h0; exp_addr = a;
            exp_m2r = m2r; exp_wreg = wreg; exp_mis = memop; exp_req = 1'b0;
            check_outputs();
        end else begin
            if (!mem.exists(a)) mem[a] = $urandom;
            ld_val = mem[a];
            to = (d >= TO);
            k  = to ? TO - 1 : d;
            for (int j = 0; j <= k; j++) begin
                @(posedge clk); #1;
                exp_wv = 1'b0; exp_rw = 1'b0; exp_mis = 1'b0; exp_req = 1'b1;
                exp_we = wr_en && !rd_en; exp_daddr = a; exp_wdata = wd;
                check_outputs();
                dmem_ack   = (j == d);
                dmem_rdata = (j == d && is_load) ? ld_val : $urandom;
                #1 check_eq("mem_stall_access", 32'(mem_stall), 32'(j < k));
            end
            if (!to && !is_load) mem[a] = wd;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            exp_wv = 1'b1; exp_rw = !to && rw; exp_addr = a; exp_m2r = m2r; exp_wreg = wreg;
            exp_rd = is_load ? (to ? ERR : ld_val) : 32'h0;
            exp_to = exp_to | to; exp_mis = 1'b0; exp_req = 1'b0;
            check_outputs();
        end
    endtask

    initial begin
        bit          v, rd_en, wr_en;
        int          kind, d;
        logic [31:0] a;

        rst_n = 1'b0;
        ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_memread = 0;
        ex_memwrite = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_write_reg = 0;
        dmem_ack = 0; dmem_rdata = 0;
        exp_wv = 0; exp_rw = 0; exp_m2r = 0; exp_mis = 0; exp_to = 0; exp_req = 0;
        exp_we = 0; exp_rd = 0; exp_addr = 0; exp_daddr = 0; exp_wdata = 0; exp_wreg = 0;
        #3;
        check_outputs();
        check_eq("rst_mem_stall", 32'(mem_stall), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_op(1, 32'h0000_1234, 32'h0, 0, 0, 1, 0, 5'd5, 0);
        mem[32'h100] = 32'hCAFEF00D;
        do_op(1, 32'h100, 32'h0, 1, 0, 1, 1, 5'd7, 3);
        do_op(1, 32'h204, 32'h55AA55AA, 0, 1, 0, 0, 5'd0, 0);
        do_op(1, 32'h102, 32'h0, 1, 0, 1, 1, 5'd3, 0);
        do_op(1, 32'h40, 32'h0, 1, 0, 1, 1, 5'd9, 20);
        do_op(1, 32'h204, 32'h0, 1, 0, 1, 1, 5'd4, 1);

        // Randomized back-to-back traffic
        for (int i = 0; i < 300; i++) begin
            v     = ($urandom_range(0, 7) != 0);
            kind  = $urandom_range(0, 4);
            rd_en = (kind == 1 || kind == 2 || kind == 4);
            wr_en = (kind == 3 || kind == 4);
            a     = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d = ($urandom_range(0, 12) == 0) ? TO + $urandom_range(0, 4) : $urandom_range(0, 4);
            if (!rd_en && d >= TO) d = 2;
            do_op(v, a, $urandom, rd_en, wr_en, 1'($urandom), 1'($urandom),
                  5'($urandom), d);
        end

        // Reset during ACCESS
        ex_valid = 1; ex_memread = 1; ex_memwrite = 0; ex_alu_result = 32'h80;
        dmem_ack = 0;
        @(posedge clk); #1;
        check_eq("pre_rst_req", 32'(dmem_req), 32'h1);
        check_eq("pre_rst_stall", 32'(mem_stall), 32'h1);
        ex_valid = 0;
        rst_n = 1'b0;
        #1;
        exp_wv = 0; exp_rw = 0; exp_mis = 0; exp_to = 0; exp_req = 0;
        check_outputs();
        check_eq("rst_dmem_addr", dmem_addr, 32'h0);
        check_eq("rst_wb_address", wb_address, 32'h0);
        check_eq("rst_mid_stall", 32'(mem_stall), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(1, 32'h0000_0ABC, 32'h0, 0, 0, 1, 0, 5'd12, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access stage of the 5-stage MIPS pipeline. Takes the registered EX/MEM bundle, runs loads and stores against a handshaked data memory, stalls the upstream pipeline while an access is outstanding, and holds the MEM/WB register.
Its wb_rd, wb_address and wb_memtoreg outputs drive the write-back select mux directly (rd, address, memtoreg).

Parameters:
ACK_TIMEOUT, 16, max cycles in ACCESS waiting for dmem_ack before forced completion; 0 disables timeout.
ERR_DATA, 32'hDEADBEEF, read data substituted on a timed-out load.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX/MEM bundle holds a real instruction
ex_alu_result  in  32  ALU result / effective address
ex_store_data  in  32  store data (rt)
ex_memread  in  1  load
ex_memwrite  in  1  store
ex_regwrite  in  1  instruction writes register file
ex_memtoreg  in  1  write-back selects memory data
ex_write_reg  in  5  destination register
mem_stall  out  1  freeze upstream stages; EX/MEM held stable while high
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = write
dmem_addr  out  32  word address (byte address, [1:0]=0)
dmem_wdata  out  32  store data
dmem_rdata  in  32  load data, valid with dmem_ack
dmem_ack  in  1  one-cycle completion pulse
wb_valid  out  1  MEM/WB holds a real instruction
wb_rd  out  32  load data
wb_address  out  32  ALU result passthrough
wb_memtoreg  out  1  passthrough
wb_regwrite  out  1  qualified register write enable
wb_write_reg  out  5  destination register
misalign_err  out  1  one-cycle pulse, misaligned access dropped
timeout_err  out  1  sticky, set on ack timeout; cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state IDLE, timeout counter 0; every output 0, including dmem_*, wb_*, mem_stall and both errors.
- memop = ex_valid & (ex_memread | ex_memwrite). If both memread and memwrite are set, treat the instruction as a load.
- mem_stall is combinational. It is 1 when (IDLE & memop & aligned) or (ACCESS & !dmem_ack & !timeout_hit). Otherwise it is 0.
- IDLE, non-memory or ex_valid=0: next edge loads MEM/WB with wb_valid=ex_valid, passthrough fields, wb_rd=0. Latency is 1 cycle.
- IDLE, memop with ex_alu_result[1:0]!=0: no request is issued. Next edge gives wb_valid=1, wb_regwrite=0 and a misalign_err pulse for 1 cycle. No stall.
- IDLE, aligned memop: next edge sets state ACCESS, dmem_req=1, dmem_we=ex_memwrite, and latches dmem_addr/dmem_wdata. wb_valid goes 0 (bubble), counter is 0.
- ACCESS: dmem_req, dmem_addr, dmem_we and dmem_wdata stay constant. The counter increments each cycle without ack.
- ACCESS & dmem_ack: next edge sets state IDLE, dmem_req=0, wb_valid=1, wb_rd=dmem_rdata for loads (0 for stores), and wb fields from EX/MEM. mem_stall is already 0 in the ack cycle, so upstream advances on that same edge.
- Minimum load latency: accepted cycle T, req at T+1, ack at T+1, wb_valid at T+2.
- timeout_hit = ACK_TIMEOUT!=0 & counter==ACK_TIMEOUT-1 & !dmem_ack. It completes like an ack, but wb_rd=ERR_DATA, wb_regwrite=0 and timeout_err is set.
- dmem_ack seen in IDLE is ignored.
- wb_valid=0 always forces wb_regwrite=0.
- Reset mid-ACCESS aborts immediately: dmem_req drops, no MEM/WB update.
- Back-to-back memops: the second is accepted in the IDLE cycle after completion. No dead cycle is required beyond the bubble.

Test Plan:
- ALU op ex_alu_result=32'h0000_1234, regwrite=1, reg 5 -> 1 cycle later wb_valid=1, wb_address=32'h1234, wb_write_reg=5, mem_stall never high.
- Load addr 32'h100, ack 3 cycles after req with rdata 32'hCAFEF00D -> mem_stall high 4 cycles, dmem_addr=32'h100 constant, then wb_rd=32'hCAFEF00D, wb_memtoreg=1, single wb_valid pulse.
- Store addr 32'h204 data 32'h55AA55AA, same-cycle ack -> dmem_we=1, dmem_wdata=32'h55AA55AA, wb_valid=1, wb_regwrite=0 (ex_regwrite=0).
- Load addr 32'h102 -> no dmem_req, misalign_err 1-cycle pulse, wb_regwrite=0, no stall.
- ACK_TIMEOUT=16, no ack -> after 16 ACCESS cycles wb_rd=32'hDEADBEEF, wb_regwrite=0, timeout_err stays 1 until rst_n.
- rst_n low during ACCESS -> all outputs 0 asynchronously. After release, the next ALU op completes normally in 1 cycle.
